// File: rtl/tsbus_rx.sv
// tsbus_rx: single-wire bus frame receiver with 4-entry byte FIFO and
// open-drain style acknowledge pulse. Optional even-parity bit is enabled
// by defining TSBUS_PARITY_EN (default build: start + 8 data + stop).
//
// state        | meaning
// -------------+-----------------------------------------------------
// S_IDLE       | bus idle, waiting for a synchronized falling edge
// S_START      | timing to the start-bit midpoint, reject false starts
// S_DATA       | sampling 8 data bits, LSB first
// S_PARITY     | sampling the even-parity bit (TSBUS_PARITY_EN only)
// S_STOP       | sampling the stop bit, push / error / drop decision
// S_ACK        | half-bit wait, then bus_oe held for one bit period
// S_WAIT_IDLE  | after a bad frame, wait for the bus to read high
module tsbus_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_in,
  output logic       bus_oe,
  output logic       bus_drv,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef TSBUS_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  logic          bus_s1, bus_s2, bus_d;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_err;
  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          stop_tick, good, bad, full, push, pop, drop;

  assign bus_drv  = 1'b0;
  assign rx_valid = (count != 3'd0);
  assign rx_data  = mem[rd_ptr];

  // two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_s1 <= 1'b1;
      bus_s2 <= 1'b1;
      bus_d  <= 1'b1;
    end else begin
      bus_s1 <= bus_in;
      bus_s2 <= bus_s1;
      bus_d  <= bus_s2;
    end
  end

  // frame verdict at the stop-bit sample and FIFO handshake
  always_comb begin
    stop_tick = (state == S_STOP) && (cnt == '0);
    good      = stop_tick && bus_s2 && !par_err;
    bad       = stop_tick && !(bus_s2 && !par_err);
    full      = (count == 3'd4);
    pop       = rx_valid && rx_ready;
    push      = good && (!full || pop);
    drop      = good && full && !pop;
  end

  // receive / acknowledge sequencer with a shared down-counter bit timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      bus_oe    <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef TSBUS_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= bad;
      overflow  <= drop;
      case (state)
        S_IDLE: begin
          if (bus_d && !bus_s2) begin
            state <= S_START;
            cnt   <= HALF_M1;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (bus_s2) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= FULL_M1;
              bit_cnt <= '0;
`ifdef TSBUS_PARITY_EN
              par_err <= 1'b0;
`endif
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shreg   <= {bus_s2, shreg[7:1]};
            cnt     <= FULL_M1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef TSBUS_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef TSBUS_PARITY_EN
        S_PARITY: begin
          if (cnt == '0) begin
            par_err <= (^shreg) ^ bus_s2;
            state   <= S_STOP;
            cnt     <= FULL_M1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == '0) begin
            if (push) begin
              state <= S_ACK;
              cnt   <= HALF_M1;
            end else if (good) begin
              state <= S_IDLE;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ACK: begin
          // first pass times the half-bit gap, second pass the drive window
          if (cnt == '0) begin
            if (!bus_oe) begin
              bus_oe <= 1'b1;
              cnt    <= FULL_M1;
            end else begin
              bus_oe <= 1'b0;
              state  <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (bus_s2) state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

`ifndef TSBUS_PARITY_EN
  assign par_err = 1'b0;
`endif

  // 4-entry FIFO; push and pop in the same cycle both take effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: doc/tsbus_rx.md
TSBUS_RX -- requirements
Module: tsbus_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bus bit (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bus_in  input  1  shared single-wire bus, sensed value; idle high (pull-up).
REQ-005 SHALL have port bus_oe  output  1  enable for the external tri-state bus driver.
REQ-006 SHALL have port bus_drv  output  1  value presented to the tri-state driver; constant 0.
REQ-007 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad frame.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a good frame is dropped.

Function
REQ-012 SHALL pass bus_in through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-013 SHALL implement FSM IDLE, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-014 IDLE: a synchronized 1->0 transition SHALL enter START and clear the bit counter.
REQ-015 START: at count CLKS_PER_BIT/2-1 SHALL sample; 1 = false start -> IDLE with no error; 0 -> DATA.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT cycles after the start midpoint, 8 bits, LSB first.
REQ-017 STOP: SHALL sample one bit period after the last data or parity bit; good frame = stop 1 and parity OK.
REQ-018 On a good frame with FIFO not full, the byte SHALL be pushed in the STOP-sample cycle and the FSM SHALL enter ACK.
REQ-019 ACK: SHALL wait CLKS_PER_BIT/2 cycles, then drive bus_oe=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-020 Bad frame: frame_err SHALL pulse one cycle at the STOP sample, no push, no ACK, then WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL hold until the synchronized bus reads 1, then enter IDLE.
REQ-022 Good frame with FIFO full and no pop that cycle: byte dropped, overflow pulses one cycle, no ACK, then IDLE.
REQ-023 FIFO SHALL be 4 entries with a 3-bit occupancy count; pop occurs when rx_valid && rx_ready.
REQ-024 Simultaneous push and pop SHALL both take effect; at full this is not an overflow; count unchanged.
REQ-025 Pop with the FIFO empty SHALL be ignored; rx_data SHALL be stable while rx_valid=1 and no pop occurs.
REQ-026 bus_oe SHALL be asserted only in the ACK drive window; bus edges seen during ACK SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force: FSM to IDLE, counters to 0, FIFO empty, rx_valid=0, rx_data=0, bus_oe=0, frame_err=0, overflow=0.
REQ-028 Reset mid-frame or mid-ACK SHALL release the bus at once (bus_oe=0) and discard the partial frame.
REQ-029 bus_drv SHALL be 0 in and out of reset.

Configuration
REQ-030 Macro TSBUS_PARITY_EN defined: PARITY state SHALL sample one even-parity bit after data; a mismatch is a bad frame.
REQ-031 Macro TSBUS_PARITY_EN undefined: PARITY state SHALL be absent; STOP follows DATA directly; frame = start + 8 data + stop.

Verification (CLKS_PER_BIT=16, parity off unless stated)
REQ-032 Frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5; bus_oe high exactly 16 cycles starting 8 cycles after the stop sample.
REQ-033 Low glitch of 5 cycles on bus_in -> no push, no frame_err, FSM back in IDLE.
REQ-034 Stop bit driven 0 -> frame_err one pulse, no ACK, no push; FSM leaves WAIT_IDLE only after the bus returns high.
REQ-035 Five frames 0x01..0x05, rx_ready=0 -> the fifth frame gives overflow pulse and no ACK; pops then return 0x01..0x04.
REQ-036 TSBUS_PARITY_EN defined, 0x03 sent with parity 1 -> frame_err; sent with parity 0 -> accepted and ACKed.
REQ-037 rst_n low during the ACK drive window -> bus_oe=0 asynchronously; FIFO empty; next frame 0x3C is received normally.
